// File: rtl/fft_pair_sequencer.sv
// fft_pair_sequencer
//   Issue sequencer for an in-place radix-2 FFT. It sits in front of the AGU.
//   After a start pulse it issues one (stage, pair_id) per cycle. It walks
//   every pair of every stage. Between stages it waits PIPE_DEPTH cycles so
//   the write-backs of the previous stage reach memory before the next stage
//   reads them. The end of the transform is marked by a one-cycle done pulse.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a transform; only looked at in IDLE
//   stall       hold issue; only honoured in RUN
//   stage       current stage, 0..LOG2N-1
//   pair_id     current butterfly pair, 0..N/2-1
//   valid       stage/pair_id carry a live issue this cycle
//   wb_valid    valid delayed by PIPE_DEPTH cycles
//   wb_last     write-back of the last pair of the last stage
//   busy        high in RUN and WAIT
//   done        one-cycle completion pulse
module fft_pair_sequencer #(
    parameter int N          = 32,
    parameter int PIPE_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stall,
    output logic [$clog2(N)-1:0]   stage,
    output logic [$clog2(N/2)-1:0] pair_id,
    output logic                   valid,
    output logic                   wb_valid,
    output logic                   wb_last,
    output logic                   busy,
    output logic                   done
);
    localparam int LOG2N = $clog2(N);
    localparam int SW    = $clog2(N);
    localparam int PW    = $clog2(N/2);
    localparam int CW    = $clog2(PIPE_DEPTH + 1);

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [PW-1:0] LAST_PAIR  = PW'(N/2 - 1);
    localparam logic [CW-1:0] WAIT_LOAD  = CW'(PIPE_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] stage_nxt;
    logic [PW-1:0] pair_nxt;
    logic          valid_nxt, busy_nxt, done_nxt;
    logic          wait_end, last_issue;

    // Write-back tracking: index PIPE_DEPTH is the oldest entry.
    logic [PIPE_DEPTH:1] vld_pipe, last_pipe;

    // The counter holds the number of WAIT cycles left, this cycle included.
    assign wait_end   = (cnt == CW'(1));
    assign last_issue = valid && (stage == LAST_STAGE) && (pair_id == LAST_PAIR);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN:  if (!stall && pair_id == LAST_PAIR) state_nxt = S_WAIT;
            S_WAIT: if (wait_end) state_nxt = (stage == LAST_STAGE) ? S_DONE : S_RUN;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    // In RUN, the displayed pair has always been issued already, because a
    // stall only hides repeats of it. For that reason an unstalled edge
    // always advances the pair.
    always_comb begin
        stage_nxt = stage;
        pair_nxt  = pair_id;
        valid_nxt = 1'b0;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                stage_nxt = '0;
                pair_nxt  = '0;
                if (start) begin
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (pair_id == LAST_PAIR) begin
                        cnt_nxt = WAIT_LOAD;
                    end else begin
                        pair_nxt  = pair_id + PW'(1);
                        valid_nxt = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CW'(1);
                if (wait_end) begin
                    if (stage == LAST_STAGE) begin
                        busy_nxt = 1'b0;
                        done_nxt = 1'b1;
                    end else begin
                        stage_nxt = stage + SW'(1);
                        pair_nxt  = '0;
                        valid_nxt = 1'b1;
                    end
                end
            end
            S_DONE: begin
                stage_nxt = '0;
                pair_nxt  = '0;
                busy_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage     <= '0;
            pair_id   <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else begin
            stage        <= stage_nxt;
            pair_id      <= pair_nxt;
            valid        <= valid_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            cnt          <= cnt_nxt;
            vld_pipe[1]  <= valid;
            last_pipe[1] <= last_issue;
            for (int i = 2; i <= PIPE_DEPTH; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
        end
    end

    assign wb_valid = vld_pipe[PIPE_DEPTH];
    assign wb_last  = last_pipe[PIPE_DEPTH];

endmodule

// File: tb/tb_fft_pair_sequencer.sv
// Directed bench for fft_pair_sequencer. It uses two instances:
// N=32,PIPE_DEPTH=2 and N=8,PIPE_DEPTH=1.
// All DUT outputs are sampled on the falling edge. Inputs are driven there too.
module tb_fft_pair_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start32, stall32, start8, stall8;
    logic [4:0] stage32;
    logic [3:0] pair32;
    logic valid32, wbv32, wbl32, busy32, done32;
    logic [2:0] stage8;
    logic [1:0] pair8;
    logic valid8, wbv8, wbl8, busy8, done8;

    fft_pair_sequencer #(.N(32), .PIPE_DEPTH(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .stall(stall32),
        .stage(stage32), .pair_id(pair32), .valid(valid32), .wb_valid(wbv32),
        .wb_last(wbl32), .busy(busy32), .done(done32));

    fft_pair_sequencer #(.N(8), .PIPE_DEPTH(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .stall(stall8),
        .stage(stage8), .pair_id(pair8), .valid(valid8), .wb_valid(wbv8),
        .wb_last(wbl8), .busy(busy8), .done(done8));

    int errors = 0;
    int checks = 0;
    bit sel8   = 1'b0;   // selects which instance the run task drives/observes

    int   s_stage, s_pair;
    logic s_valid, s_wbv, s_wbl, s_busy, s_done;
    always_comb begin
        if (sel8) begin
            s_stage = int'(stage8);  s_pair = int'(pair8);
            s_valid = valid8; s_wbv = wbv8; s_wbl = wbl8; s_busy = busy8; s_done = done8;
        end else begin
            s_stage = int'(stage32); s_pair = int'(pair32);
            s_valid = valid32; s_wbv = wbv32; s_wbl = wbl32; s_busy = busy32; s_done = done32;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel8) start8 = v; else start32 = v;
    endtask

    task automatic set_stall(input logic v);
        if (sel8) stall8 = v; else stall32 = v;
    endtask

    // Pulse start, then follow the transform cycle by cycle, with these options:
    // - stall st_n cycles after issue (st_s,st_p);
    // - keep start high (and re-pulse it in DONE);
    // - pull reset low after issue (rs_s,rs_p).
    // cyc counts falling edges after the edge that sampled start.
    task automatic run(input int npairs, input int pd,
                       input int st_s, input int st_p, input int st_n,
                       input bit hold, input int rs_s, input int rs_p,
                       output int issues, output int busy_cnt, output int done_cnt,
                       output int done_cyc, output int wbl_cyc, output int wbl_cnt);
        int es, ep, stall_left, cyc;
        bit stop;
        bit hist [0:255];
        es = 0; ep = 0; stall_left = 0; cyc = 0; stop = 1'b0;
        issues = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1; wbl_cyc = -1; wbl_cnt = 0;
        for (int i = 0; i < 256; i++) hist[i] = 1'b0;
        @(negedge clk);
        set_start(1'b1);
        while (!stop && cyc < 250) begin
            @(negedge clk);
            cyc++;
            hist[cyc] = s_valid;
            if (stall_left > 0) begin
                check("stall_valid", int'(s_valid), 0);
                check("stall_pair", s_pair, st_p);
                stall_left--;
                if (stall_left == 0) set_stall(1'b0);
            end
            if (s_valid) begin
                check("issue_order", s_stage * 64 + s_pair, es * 64 + ep);
                issues++;
                ep++;
                if (ep == npairs) begin ep = 0; es++; end
            end
            if (cyc >= pd) check("wb_valid", int'(s_wbv), int'(hist[cyc - pd]));
            if (s_wbl) begin wbl_cnt++; wbl_cyc = cyc; end
            if (s_busy) busy_cnt++;
            if (s_done) begin done_cnt++; done_cyc = cyc; end
            if (s_valid && s_stage == st_s && s_pair == st_p) begin
                stall_left = st_n;
                set_stall(1'b1);
            end
            set_start(hold && (done_cnt == 0 || done_cyc == cyc));
            if (s_valid && s_stage == rs_s && s_pair == rs_p) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", int'(s_valid), 0);
                check("rst_busy",  int'(s_busy), 0);
                check("rst_stage", s_stage, 0);
                check("rst_pair",  s_pair, 0);
                check("rst_wbv",   int'(s_wbv), 0);
                check("rst_done",  int'(s_done), 0);
                set_start(1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                stop = 1'b1;
            end
            if (done_cyc > 0 && cyc == done_cyc + 2) begin
                // Two cycles after done the block is idle and was not restarted.
                check("idle_valid", int'(s_valid), 0);
                check("idle_busy",  int'(s_busy), 0);
                check("idle_stage", s_stage, 0);
                check("idle_pair",  s_pair, 0);
                stop = 1'b1;
            end
        end
        set_start(1'b0);
        set_stall(1'b0);
        repeat (2) @(negedge clk);
    endtask

    int issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt;

    initial begin
        rst_n = 1'b0; start32 = 1'b0; stall32 = 1'b0; start8 = 1'b0; stall8 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid32", int'(valid32), 0);
        check("reset_busy32",  int'(busy32), 0);
        check("reset_sp32",    int'({stage32, pair32}), 0);
        check("reset_wb32",    int'({wbv32, wbl32, done32}), 0);
        check("reset_all8",    int'({stage8, pair8, valid8, wbv8, wbl8, busy8, done8}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain N=32 transform
        sel8 = 1'b0;
        run(16, 2, -1, -1, 0, 1'b0, -1, -1, issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt);
        check("t1_issues", issues, 80);
        check("t1_busy", busy_cnt, 90);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_cyc", done_cyc, 91);
        check("t1_wbl_cyc", wbl_cyc, 90);
        check("t1_wbl_cnt", wbl_cnt, 1);

        // 3-cycle stall after issue (2,7)
        run(16, 2, 2, 7, 3, 1'b0, -1, -1, issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt);
        check("t2_issues", issues, 80);
        check("t2_busy", busy_cnt, 93);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_done_cyc", done_cyc, 94);
        check("t2_wbl_cyc", wbl_cyc, 93);

        // start held high through RUN and re-pulsed in DONE
        run(16, 2, -1, -1, 0, 1'b1, -1, -1, issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt);
        check("t3_issues", issues, 80);
        check("t3_busy", busy_cnt, 90);
        check("t3_done_cnt", done_cnt, 1);
        check("t3_done_cyc", done_cyc, 91);

        // reset asserted right after issue (3,4); no done pulse appears
        run(16, 2, -1, -1, 0, 1'b0, 3, 4, issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt);
        check("t4_issues", issues, 53);
        check("t4_done_cnt", done_cnt, 0);

        // clean transform after that reset
        run(16, 2, -1, -1, 0, 1'b0, -1, -1, issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt);
        check("t5_issues", issues, 80);
        check("t5_busy", busy_cnt, 90);
        check("t5_done_cyc", done_cyc, 91);

        // N=8, PIPE_DEPTH=1: issue (2,3) at cycle 14, wb_last at 15, done at 16
        sel8 = 1'b1;
        run(4, 1, -1, -1, 0, 1'b0, -1, -1, issues, busy_cnt, done_cnt, done_cyc, wbl_cyc, wbl_cnt);
        check("t6_issues", issues, 12);
        check("t6_busy", busy_cnt, 15);
        check("t6_done_cnt", done_cnt, 1);
        check("t6_done_cyc", done_cyc, 16);
        check("t6_wbl_cyc", wbl_cyc, 15);
        check("t6_wbl_cnt", wbl_cnt, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
